// File: rtl/mure_pkg.sv
// mure_pkg: shared state type and statistics width for the retirement scheduler.
package mure_pkg;
    typedef enum logic {IDLE, EMIT} sched_state_e;
    localparam int STAT_W = 32;
endpackage

// File: rtl/mure_ff1.sv
// mure_ff1: find-first-one over a slot mask; returns the lowest set index, its
// one-hot form, and whether exactly one bit is set.
module mure_ff1 #(
    parameter int N     = 2,
    parameter int SEL_W = 1
) (
    input  logic [N-1:0]     i_vec,
    output logic [SEL_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot,
    output logic             o_single
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) if (i_vec[i]) o_idx = SEL_W'(i);
    end
    assign o_onehot = i_vec & (~i_vec + N'(1));
    assign o_single = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);
endmodule

// File: rtl/mure_retire_sched.sv
// mure_retire_sched: serializes multi-slot retirement groups into single trace beats.
// Optional MURE_SCHED_STATS_EN adds saturating beat/stall/group counters.
module mure_retire_sched
    import mure_pkg::*;
#(
    parameter int  NrRetiredInstr = 2,
    localparam int SEL_W          = NrRetiredInstr > 1 ? $clog2(NrRetiredInstr) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      fifo_empty_i,
    input  logic [NrRetiredInstr-1:0] slot_valid_i,
    input  logic                      exc_valid_i,
    input  logic                      out_ready_i,
    output logic                      out_valid_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      last_o,
    output logic                      pop_o,
    output logic                      busy_o
`ifdef MURE_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]         stat_beats_o,
    output logic [STAT_W-1:0]         stat_stall_o,
    output logic [STAT_W-1:0]         stat_groups_o
`endif
);
    localparam int N = NrRetiredInstr;

    sched_state_e r_state, w_state_nxt;
    logic [N-1:0]     r_pending, w_pending_nxt, w_mask, w_onehot;
    logic [SEL_W-1:0] w_idx;
    logic             w_single, w_emit, w_hs, w_idle_pop;

    mure_ff1 #(.N(N), .SEL_W(SEL_W)) u_ff1 (
        .i_vec    (r_pending),
        .o_idx    (w_idx),
        .o_onehot (w_onehot),
        .o_single (w_single)
    );

    // An exception with no retired slots still needs one beat to carry the common fields.
    assign w_mask      = (slot_valid_i == '0 && exc_valid_i) ? N'(1) : slot_valid_i;
    assign w_emit      = r_state == EMIT;
    assign out_valid_o = w_emit & ~flush_i;
    assign sel_o       = out_valid_o ? w_idx : '0;
    assign last_o      = out_valid_o & w_single;
    assign w_hs        = out_valid_o & out_ready_i;
    assign w_idle_pop  = rst_ni & ~w_emit & ~fifo_empty_i & ~flush_i & (w_mask == '0);
    assign pop_o       = w_idle_pop | (w_hs & w_single);
    assign busy_o      = w_emit;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        if (flush_i) begin
            w_state_nxt   = IDLE;
            w_pending_nxt = '0;
        end else if (!w_emit) begin
            if (!fifo_empty_i && w_mask != '0) begin
                w_state_nxt   = EMIT;
                w_pending_nxt = w_mask;
            end
        end else if (w_hs) begin
            w_pending_nxt = r_pending & ~w_onehot;
            w_state_nxt   = w_single ? IDLE : EMIT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
        end
    end

`ifdef MURE_SCHED_STATS_EN
    logic [STAT_W-1:0] r_beats, r_stall, r_groups;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beats  <= '0;
            r_stall  <= '0;
            r_groups <= '0;
        end else begin
            if (w_hs && r_beats != '1) r_beats <= r_beats + STAT_W'(1);
            if (out_valid_o && !out_ready_i && r_stall != '1) r_stall <= r_stall + STAT_W'(1);
            if (pop_o && r_groups != '1) r_groups <= r_groups + STAT_W'(1);
        end
    end
    assign stat_beats_o  = r_beats;
    assign stat_stall_o  = r_stall;
    assign stat_groups_o = r_groups;
`endif
endmodule

// File: tb/tb_mure_retire_sched.sv
// tb_mure_retire_sched: directed and random checks of a 4-slot and a 2-slot scheduler
// against a beat-list reference model.
module tb_mure_retire_sched;
    logic clk = 1'b0, rst_n = 1'b0;
    logic flush = 1'b0, fifo_empty = 1'b1, exc_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] slot_valid = '0;
    logic [1:0] sv2;
    logic v4, v2, l4, l2, p4, p2, b4, b2;
    logic [1:0] s4;
    logic [0:0] s2;
    int total = 0, bad = 0;
    bit mb[2];
    int lst[2][4];
    int cnt[2], hd[2];
    int m_beats = 0, m_stall = 0, m_groups = 0;

    always #5 clk = ~clk;
    assign sv2 = slot_valid[1:0];

`ifdef MURE_SCHED_STATS_EN
    logic [31:0] sb, ss, sg, sb2, ss2, sg2;
`endif

    mure_retire_sched #(.NrRetiredInstr(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
        .slot_valid_i(slot_valid), .exc_valid_i(exc_valid), .out_ready_i(out_ready),
        .out_valid_o(v4), .sel_o(s4), .last_o(l4), .pop_o(p4), .busy_o(b4)
`ifdef MURE_SCHED_STATS_EN
        , .stat_beats_o(sb), .stat_stall_o(ss), .stat_groups_o(sg)
`endif
    );

    mure_retire_sched #(.NrRetiredInstr(2)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
        .slot_valid_i(sv2), .exc_valid_i(exc_valid), .out_ready_i(out_ready),
        .out_valid_o(v2), .sel_o(s2), .last_o(l2), .pop_o(p2), .busy_o(b2)
`ifdef MURE_SCHED_STATS_EN
        , .stat_beats_o(sb2), .stat_stall_o(ss2), .stat_groups_o(sg2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".u4"}, {27'd0, v4, s4, l4, p4, b4}, 32'd0);
        chk({tag, ".u2"}, {28'd0, v2, s2, l2, p2, b2}, 32'd0);
    endtask

    task automatic step(input logic emp, input logic [3:0] sv, input logic exc,
                        input logic rdy, input logic fl, input string tag);
        @(negedge clk);
        fifo_empty = emp; slot_valid = sv; exc_valid = exc; out_ready = rdy; flush = fl;
        #1;
        for (int d = 0; d < 2; d++) begin
            logic [3:0] m;
            logic ev, ep, el;
            int es;
            string t;
            t  = $sformatf("%s.u%0d", tag, d == 0 ? 4 : 2);
            m  = d == 0 ? sv : {2'b00, sv[1:0]};
            ev = mb[d] && !fl;
            el = mb[d] && hd[d] == cnt[d] - 1;
            es = mb[d] ? lst[d][hd[d]] : 0;
            ep = mb[d] ? (ev && rdy && el) : (!emp && m == 4'd0 && !exc && !fl);
            chk({t, ".valid"}, 32'(d == 0 ? v4 : v2), 32'(ev));
            chk({t, ".pop"},   32'(d == 0 ? p4 : p2), 32'(ep));
            chk({t, ".busy"},  32'(d == 0 ? b4 : b2), 32'(mb[d]));
            if (ev) begin
                chk({t, ".sel"},  32'(d == 0 ? s4 : {1'b0, s2}), 32'(es));
                chk({t, ".last"}, 32'(d == 0 ? l4 : l2), 32'(el));
            end
            if (d == 0) begin
                if (ev && rdy) m_beats++;
                if (ev && !rdy) m_stall++;
                if (ep) m_groups++;
            end
            if (fl) mb[d] = 0;
            else if (!mb[d]) begin
                if (!emp && (m != 4'd0 || exc)) begin
                    cnt[d] = 0; hd[d] = 0;
                    for (int i = 0; i < 4; i++) if (m[i]) begin lst[d][cnt[d]] = i; cnt[d]++; end
                    if (cnt[d] == 0) begin lst[d][0] = 0; cnt[d] = 1; end
                    mb[d] = 1;
                end
            end else if (rdy) begin
                hd[d]++;
                if (hd[d] == cnt[d]) mb[d] = 0;
            end
        end
    endtask

    initial begin
        #1 chk_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        // two-slot group, both slots retired
        step(0, 4'b0011, 0, 1, 0, "p1_idle");
        step(0, 4'b0011, 0, 1, 0, "p1_b0");
        step(0, 4'b0011, 0, 1, 0, "p1_b1");
        step(1, 4'b0011, 0, 1, 0, "p1_done");
        // slot 0 skipped
        step(0, 4'b0010, 0, 1, 0, "p2_idle");
        step(0, 4'b0010, 0, 1, 0, "p2_b");
        step(1, 4'b0010, 0, 1, 0, "p2_done");
        // exception-only and empty groups
        step(0, 4'b0000, 1, 1, 0, "p3_idle");
        step(0, 4'b0000, 1, 1, 0, "p3_b");
        step(1, 4'b0000, 0, 1, 0, "p3_done");
        step(0, 4'b0000, 0, 1, 0, "p3_discard");
        step(1, 4'b0000, 0, 1, 0, "p3_after");
        // sparse 4-slot mask with a 3-cycle stall on the second beat
        step(0, 4'b1011, 0, 1, 0, "p4_idle");
        step(0, 4'b1011, 0, 1, 0, "p4_b0");
        for (int k = 0; k < 3; k++) step(0, 4'b1011, 0, 0, 0, "p4_stall");
        step(0, 4'b1011, 0, 1, 0, "p4_b1");
        step(0, 4'b1011, 0, 1, 0, "p4_b3");
        step(1, 4'b1011, 0, 1, 0, "p4_done");
        step(1, 4'b0000, 0, 1, 0, "p4_quiet");
`ifdef MURE_SCHED_STATS_EN
        chk("p4_stat_stall", ss, 32'd3);
`endif
        // flush on the second beat, then the same head is replayed
        step(0, 4'b0011, 0, 1, 0, "p5_idle");
        step(0, 4'b0011, 0, 1, 0, "p5_b0");
        step(0, 4'b0011, 0, 1, 1, "p5_flush");
        step(0, 4'b0011, 0, 1, 0, "p5_reidle");
        step(0, 4'b0011, 0, 1, 0, "p5_rb0");
        step(0, 4'b0011, 0, 1, 0, "p5_rb1");
        step(1, 4'b0011, 0, 1, 0, "p5_done");
        // asynchronous reset in the middle of a group
        step(0, 4'b0011, 0, 1, 0, "p6_idle");
        step(0, 4'b0011, 0, 0, 0, "p6_stall");
        rst_n = 1'b0;
        #1 chk_zero("p6_rst");
        mb[0] = 0; mb[1] = 0; m_beats = 0; m_stall = 0; m_groups = 0;
        @(negedge clk);
        #1 chk_zero("p6_rst_hold");
        fifo_empty = 1'b1;
        rst_n = 1'b1;
        step(0, 4'b0011, 0, 1, 0, "p6_idle2");
        step(0, 4'b0011, 0, 1, 0, "p6_b0");
        step(0, 4'b0011, 0, 1, 0, "p6_b1");
        for (int k = 0; k < 400; k++) begin
            bit any;
            any = mb[0] || mb[1];
            step(any ? 1'b0 : 1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), "rnd");
        end
`ifdef MURE_SCHED_STATS_EN
        chk("stat_beats", sb, 32'(m_beats));
        chk("stat_stall", ss, 32'(m_stall));
        chk("stat_groups", sg, 32'(m_groups));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mure_retire_sched.md
Name: mure_retire_sched

Overview:
- Scheduler that serializes multi-port retirement groups into the single-beat trace encoder interface.
- Sits between the per-commit-port ingress FIFOs, including the common cause/tval/priv FIFO, and the output mux feeding the trace encoder.
- Walks only the slots whose iretire bit is set, drives the mux select, and holds each beat under a valid/ready handshake.
- Pops all ingress FIFOs together once the last beat of a group is accepted.

Parameters:
- NrRetiredInstr, 2, number of commit ports (slots per group), must be >= 1.
- SEL_W (localparam), NrRetiredInstr>1 ? $clog2(NrRetiredInstr) : 1, width of the slot select.

Ports:
- clk_i  in  1  clock, one clock domain only.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous abort of the current group; no pop is issued.
- fifo_empty_i  in  1  ingress FIFO set is empty (all FIFOs are pushed together).
- slot_valid_i  in  NrRetiredInstr  iretire bits of the head group.
- exc_valid_i  in  1  head common entry carries an exception/interrupt.
- out_ready_i  in  1  trace encoder accepts the current beat.
- out_valid_o  out  1  beat valid.
- sel_o  out  SEL_W  mux select (slot index) for the current beat.
- last_o  out  1  current beat is the last of its group; common fields are meaningful only on this beat.
- pop_o  out  1  single-cycle pop of every ingress FIFO.
- busy_o  out  1  a group is in progress (state != IDLE).

Behaviour:
- Reset (async, rst_ni=0): state=IDLE, pending_q=0. All outputs are 0.
- State IDLE, fifo_empty_i=1: outputs stay 0.
- State IDLE, fifo_empty_i=0:
  - mask = slot_valid_i.
  - If mask==0 and exc_valid_i=1, mask = 1 (one beat on slot 0, exception-only group).
  - If mask==0 and exc_valid_i=0: pop_o=1 this cycle combinationally, stay IDLE (empty group discarded, no beat emitted).
  - Otherwise pending_q<=mask and go to EMIT next cycle.
- State EMIT:
  - out_valid_o=1.
  - sel_o = index of the lowest set bit of pending_q.
  - last_o = (pending_q has exactly one bit set).
- Handshake (out_valid_o & out_ready_i):
  - Clear the selected bit in pending_q.
  - If last_o=1: pop_o=1 in that same cycle and go to IDLE.
- While out_valid_o=1 and out_ready_i=0: sel_o and last_o are held stable and pending_q is unchanged. Valid is never dropped without a handshake.
- Throughput: popcount(mask) beats per group, plus 1 IDLE cycle per group. The first beat appears 1 cycle after fifo_empty_i falls.
- flush_i=1 (any state): next cycle state=IDLE and pending_q=0. pop_o=0 and out_valid_o=0 in the flush cycle. flush_i has priority over a handshake in the same cycle.
- slot_valid_i and exc_valid_i are sampled only in IDLE; changes at the FIFO head during EMIT are ignored.
- pop_o is never asserted while fifo_empty_i=1.
- NrRetiredInstr=1: sel_o is always 0 and last_o=1 on every beat.

Optional Feature:
- Macro MURE_SCHED_STATS_EN.
- When defined, adds three outputs, each 32-bit:
  - stat_beats_o: accepted handshakes.
  - stat_stall_o: cycles with out_valid_o & !out_ready_i.
  - stat_groups_o: pop_o pulses.
- The counters saturate at 0xFFFFFFFF, reset to 0, and are not cleared by flush_i.
- When not defined, the ports and counters do not exist and the core behaviour is identical.

Decomposition:
- mure_pkg holds:
  - enum sched_state_e {IDLE, EMIT}.
  - STAT_W=32.
- Sub-module mure_ff1 (parameterised find-first-one): inputs a NrRetiredInstr vector; outputs index (SEL_W), onehot, and single_bit flag. It drives sel_o, the bit clear and last_o.

Test Plan:
1. NrRetiredInstr=2, head slot_valid=2'b11, out_ready_i=1:
   - Beats are sel 0 (last 0), then sel 1 (last 1).
   - pop_o pulses with the second beat; busy_o drops the next cycle.
2. slot_valid=2'b10:
   - A single beat is issued, sel_o=1, last_o=1.
   - Slot 0 is skipped; pop_o pulses with that beat.
3. slot_valid=2'b00, exc_valid=1:
   - One beat, sel_o=0, last_o=1.
   - With exc_valid=0 instead: pop_o=1 in IDLE and no out_valid_o.
4. NrRetiredInstr=4, mask=4'b1011, out_ready_i low for 3 cycles on the second beat:
   - sel 0,1,3 in order.
   - sel_o=1 is held for 3 stall cycles; the stall counter reads 3 under MURE_SCHED_STATS_EN.
5. Flush on the second beat of 2'b11:
   - Next cycle IDLE, no pop_o.
   - The same head group is then replayed from sel 0.
6. rst_ni asserted mid-EMIT:
   - All outputs are 0 immediately (async).
   - After release the block resumes in IDLE and re-reads the FIFO head.
